// File: rtl/panel_switch_conditioner_pkg.sv
// Shared constants for the front-panel switch conditioner: default timing,
// panel channel assignments and the auto-repeat state codes.
package panel_switch_conditioner_pkg;

    localparam int DEF_NCH          = 8;
    localparam int DEF_DEB_CYCLES   = 16;
    localparam int DEF_REPEAT_DELAY = 64;
    localparam int DEF_REPEAT_RATE  = 16;
    localparam int DEF_NSEL         = 6;

    // Physical switch positions on the panel connector
    localparam int CLEAR_CH     = 0;
    localparam int EXTD_ADDR_CH = 1;
    localparam int ADDR_LOAD_CH = 2;
    localparam int DEP_CH       = 3;
    localparam int EXAM_CH      = 4;
    localparam int SING_STEP_CH = 5;
    localparam int CONT_CH      = 6;
    localparam int DSEL_CH      = 7;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_e;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/panel_switch_conditioner_if.sv
// Panel-side and consumer-side signals of the switch conditioner, bundled so
// front_panel and D_mux logic connect through a single port.
interface panel_switch_conditioner_if
    import panel_switch_conditioner_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int NSEL = DEF_NSEL
);
    localparam int IW = idxWidth(NSEL);

    logic [NCH-1:0]  sw_in;
    logic [NCH-1:0]  repeat_en;
    logic            run;
    logic [NCH-1:0]  run_mask;
    logic [NCH-1:0]  sw_level;
    logic [NCH-1:0]  sw_pulse;
    logic [NSEL-1:0] dsel;
    logic [IW-1:0]   dsel_idx;

    modport master (
        output sw_in, repeat_en, run, run_mask,
        input  sw_level, sw_pulse, dsel, dsel_idx
    );

    modport slave (
        input  sw_in, repeat_en, run, run_mask,
        output sw_level, sw_pulse, dsel, dsel_idx
    );

endinterface

// File: rtl/panel_switch_conditioner_debounce_ch.sv
// One switch channel: two-flop synchroniser, debounce counter, press-edge
// pulse and the auto-repeat FSM that re-fires while the switch stays held.
module panel_debounce_ch
    import panel_switch_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_i,
    input  logic repeatEn_i,
    input  logic gate_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CW = idxWidth(DEB_CYCLES);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW = idxWidth(TMAX);

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);

    logic            sync1_q, sync2_q;
    logic [CW-1:0]   debCnt_q, debCnt_d;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;
    rep_state_e      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            debCnt_q <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            state_q  <= REP_IDLE;
            timer_q  <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            debCnt_q <= debCnt_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
        end
    end

    // The level flips on the sample that would bring the count to DEB_CYCLES
    always_comb begin
        debCnt_d = '0;
        level_d  = level_q;
        if (sync2_q != level_q) begin
            if (debCnt_q == DEB_LAST) begin
                level_d = ~level_q;
            end else begin
                debCnt_d = debCnt_q + CW'(1);
            end
        end
    end

    // Decisions use the next level so pulses line up with the level they belong to
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        case (state_q)
            REP_IDLE: begin
                if (level_d && !level_q && !gate_i) begin
                    pulse_d = 1'b1;
                    if (repeatEn_i) begin
                        state_d = REP_DELAY;
                        timer_d = DELAY_LOAD;
                    end
                end
            end
            REP_DELAY, REP_REPEAT: begin
                if (!level_d || !repeatEn_i || gate_i) begin
                    state_d = REP_IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    pulse_d = 1'b1;
                    state_d = REP_REPEAT;
                    timer_d = RATE_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = REP_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/panel_switch_conditioner.sv
// Front-panel switch conditioner: NCH independent debounce/repeat channels and
// the wrapping one-hot display-select ring driven by the dsel switch.
module panel_switch_conditioner
    import panel_switch_conditioner_pkg::*;
#(
    parameter int NCH          = DEF_NCH,
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int NSEL         = DEF_NSEL,
    parameter int DSEL_CH      = panel_switch_conditioner_pkg::DSEL_CH
) (
    input  logic                          clk,
    input  logic                          reset,
    panel_switch_conditioner_if.slave     bus
);

    localparam int IW = idxWidth(NSEL);
    localparam logic [IW-1:0] IDX_LAST = IW'(NSEL - 1);

    logic [NCH-1:0]  level;
    logic [NCH-1:0]  pulse;
    logic [NSEL-1:0] dsel_q, dsel_d;
    logic [IW-1:0]   dselIdx_q, dselIdx_d;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        panel_debounce_ch #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .sw_i       (bus.sw_in[g]),
            .repeatEn_i (bus.repeat_en[g]),
            .gate_i     (bus.run & bus.run_mask[g]),
            .level_o    (level[g]),
            .pulse_o    (pulse[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dsel_q    <= NSEL'(1);
            dselIdx_q <= '0;
        end else begin
            dsel_q    <= dsel_d;
            dselIdx_q <= dselIdx_d;
        end
    end

    // Rotation preserves the single set bit, so dsel can never go zero or multi-hot
    always_comb begin
        dsel_d    = dsel_q;
        dselIdx_d = dselIdx_q;
        if (pulse[DSEL_CH]) begin
            dsel_d    = {dsel_q[NSEL-2:0], dsel_q[NSEL-1]};
            dselIdx_d = (dselIdx_q == IDX_LAST) ? '0 : dselIdx_q + IW'(1);
        end
    end

    assign bus.sw_level = level;
    assign bus.sw_pulse = pulse;
    assign bus.dsel     = dsel_q;
    assign bus.dsel_idx = dselIdx_q;

endmodule

// File: tb/tb_panel_switch_conditioner.sv
// Bench for panel_switch_conditioner: table of held-input phases with expected
// levels/pulse counts, a reset-mid-press sequence, and random stimulus vs a model.
module tb_panel_switch_conditioner;
    import panel_switch_conditioner_pkg::*;

    localparam int NCH    = 8;
    localparam int NSEL   = 6;
    localparam int DEB    = 4;
    localparam int RDELAY = 20;
    localparam int RRATE  = 5;
    localparam int DSEL   = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    panel_switch_conditioner_if #(.NCH(NCH), .NSEL(NSEL)) bus();

    panel_switch_conditioner #(
        .NCH(NCH), .DEB_CYCLES(DEB), .REPEAT_DELAY(RDELAY),
        .REPEAT_RATE(RRATE), .NSEL(NSEL), .DSEL_CH(DSEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    int phasePulses = 0;

    // Reference model: behaviour in terms of raw-sample history, run lengths
    // and elapsed time since the press
    bit mHist1[NCH], mHist2[NCH], mLevel[NCH], mPulse[NCH], mRepActive[NCH];
    int mRunLen[NCH], mPressTime[NCH];
    int mIdx = 0;
    int cyc = 0;

    typedef struct {
        logic [NCH-1:0] sw;
        logic [NCH-1:0] rep;
        logic           run;
        logic [NCH-1:0] mask;
        int             cycles;
        logic [NCH-1:0] expLevel;
        int             expPulses;
        int             expIdx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void modelReset();
        for (int i = 0; i < NCH; i++) begin
            mHist1[i] = 0; mHist2[i] = 0; mLevel[i] = 0; mPulse[i] = 0;
            mRepActive[i] = 0; mRunLen[i] = 0; mPressTime[i] = 0;
        end
        mIdx = 0;
    endfunction

    task automatic modelEdge();
        bit s, newLvl, gate, p, prevDsel;
        int el;
        cyc++;
        if (reset) begin
            modelReset();
            return;
        end
        prevDsel = mPulse[DSEL];
        for (int i = 0; i < NCH; i++) begin
            s = mHist2[i];
            mHist2[i] = mHist1[i];
            mHist1[i] = bus.sw_in[i];
            newLvl = mLevel[i];
            if (s != mLevel[i]) begin
                mRunLen[i]++;
                if (mRunLen[i] == DEB) begin
                    newLvl = s;
                    mRunLen[i] = 0;
                end
            end else begin
                mRunLen[i] = 0;
            end
            gate = bus.run & bus.run_mask[i];
            p = 0;
            if (newLvl && !mLevel[i]) begin
                mRepActive[i] = 0;
                if (!gate) begin
                    p = 1;
                    mPressTime[i] = cyc;
                    mRepActive[i] = bus.repeat_en[i];
                end
            end else if (mRepActive[i]) begin
                if (!newLvl || !bus.repeat_en[i] || gate) begin
                    mRepActive[i] = 0;
                end else begin
                    el = cyc - mPressTime[i];
                    if (el >= RDELAY && (el - RDELAY) % RRATE == 0) p = 1;
                end
            end
            mLevel[i] = newLvl;
            mPulse[i] = p;
        end
        if (prevDsel) mIdx = (mIdx + 1) % NSEL;
    endtask

    task automatic checkOutput();
        logic [NCH-1:0] eL, eP;
        logic [NSEL-1:0] eD;
        for (int i = 0; i < NCH; i++) begin
            eL[i] = mLevel[i];
            eP[i] = mPulse[i];
        end
        eD = NSEL'(1) << mIdx;
        check("model_sw_level", 32'(bus.sw_level), 32'(eL));
        check("model_sw_pulse", 32'(bus.sw_pulse), 32'(eP));
        check("model_dsel", 32'(bus.dsel), 32'(eD));
        check("model_dsel_idx", 32'(bus.dsel_idx), 32'(mIdx));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
        phasePulses += $countones(bus.sw_pulse);
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] sw, input logic [NCH-1:0] rep,
                                 input logic run, input logic [NCH-1:0] mask);
        bus.sw_in     = sw;
        bus.repeat_en = rep;
        bus.run       = run;
        bus.run_mask  = mask;
    endtask

    task automatic runVec(input int n, input vec_t v);
        applyStimulus(v.sw, v.rep, v.run, v.mask);
        phasePulses = 0;
        repeat (v.cycles) stepCycle();
        check($sformatf("vec%0d_level", n), 32'(bus.sw_level), 32'(v.expLevel));
        check($sformatf("vec%0d_pulses", n), 32'(phasePulses), 32'(v.expPulses));
        check($sformatf("vec%0d_idx", n), 32'(bus.dsel_idx), 32'(v.expIdx));
        check($sformatf("vec%0d_dsel", n), 32'(bus.dsel), 32'(NSEL'(1) << v.expIdx));
    endtask

    task automatic randomSegment();
        logic [NCH-1:0] sw, flip;
        int hold;
        flip = NCH'($urandom & $urandom);
        sw = bus.sw_in ^ flip;
        if ($urandom_range(0, 4) == 0) hold = $urandom_range(20, 45);
        else hold = $urandom_range(1, 14);
        applyStimulus(sw, NCH'($urandom | $urandom),
                      ($urandom_range(0, 3) == 0), NCH'($urandom));
        reset = ($urandom_range(0, 60) == 0);
        stepCycle();
        reset = 1'b0;
        repeat (hold - 1) stepCycle();
    endtask

    initial begin
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 10, 8'h00, 0, 0});
        vecs.push_back('{8'h01, 8'h00, 1'b0, 8'h00,  3, 8'h00, 0, 0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00,  8, 8'h00, 0, 0});
        vecs.push_back('{8'h04, 8'h00, 1'b0, 8'h00, 40, 8'h04, 1, 0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 10, 8'h00, 0, 0});
        vecs.push_back('{8'h08, 8'h08, 1'b0, 8'h00, 60, 8'h08, 8, 0});
        vecs.push_back('{8'h00, 8'h08, 1'b0, 8'h00, 10, 8'h00, 1, 0});
        vecs.push_back('{8'h40, 8'h00, 1'b1, 8'h40, 12, 8'h40, 0, 0});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 8'h40, 10, 8'h00, 0, 0});
        vecs.push_back('{8'h40, 8'h00, 1'b0, 8'h40, 12, 8'h40, 1, 0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h40, 10, 8'h00, 0, 0});
        for (int k = 1; k <= 7; k++) begin
            vecs.push_back('{8'h80, 8'h00, 1'b0, 8'h00, 10, 8'h80, 1, k % NSEL});
            vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 10, 8'h00, 0, k % NSEL});
        end

        reset = 1'b1;
        applyStimulus('0, '0, 1'b0, '0);
        modelReset();
        repeat (3) stepCycle();
        check("reset_level", 32'(bus.sw_level), 32'd0);
        check("reset_pulse", 32'(bus.sw_pulse), 32'd0);
        check("reset_dsel", 32'(bus.dsel), 32'h01);
        check("reset_idx", 32'(bus.dsel_idx), 32'd0);
        reset = 1'b0;

        foreach (vecs[n]) runVec(n, vecs[n]);

        // Reset while the dsel switch is held: everything clears, then one fresh press
        applyStimulus(8'h80, 8'h00, 1'b0, 8'h00);
        phasePulses = 0;
        repeat (10) stepCycle();
        check("midrst_pre_level", 32'(bus.sw_level), 32'h80);
        check("midrst_pre_idx", 32'(bus.dsel_idx), 32'd2);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        check("midrst_level", 32'(bus.sw_level), 32'd0);
        check("midrst_dsel", 32'(bus.dsel), 32'h01);
        check("midrst_idx", 32'(bus.dsel_idx), 32'd0);
        phasePulses = 0;
        repeat (10) stepCycle();
        check("midrst_repulse", 32'(phasePulses), 32'd1);
        check("midrst_level_back", 32'(bus.sw_level), 32'h80);
        check("midrst_idx_after", 32'(bus.dsel_idx), 32'd1);
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00);
        repeat (10) stepCycle();

        for (int r = 0; r < 300; r++) randomSegment();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
